// File: rtl/rom_burst_ctrl.sv
// Purpose : burst reader over a constant ROM, word(a) = a*0x1111 + 1, one beat per cycle.
// Latency : request accepted at edge N -> first rd_valid high after edge N+2.
// Backpr. : rd_ready low holds the presented beat (data/addr/last/parity) stable; no beats lost.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_addr = start address, req_len = beats-1
//   rd_valid/rd_ready          beat handshake; rd_data/rd_addr/rd_last describe the beat
//   busy                       high while a burst is being fetched or delivered
//   rd_parity                  XOR of rd_data, present only when ROM_PARITY_EN is defined
module rom_burst_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              busy
`ifdef ROM_PARITY_EN
  ,
  output logic              rd_parity
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, BEAT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;

  // Constant ROM, fully determined at elaboration.
  logic [DATA_W-1:0] rom [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = DATA_W'(64'(g) * 64'h1111 + 64'd1);
  end

  // Address of the word loaded into the output registers on this edge:
  // the latched start address in FETCH, the successor (wrapping) in BEAT.
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_word;

  always_comb begin
    next_addr = cur_addr + ADDR_W'(1);
    load_addr = (state == FETCH) ? cur_addr : next_addr;
    load_word = rom[load_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      req_ready <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_addr   <= '0;
      rd_last   <= 1'b0;
      busy      <= 1'b0;
`ifdef ROM_PARITY_EN
      rd_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cur_addr  <= req_addr;
            remaining <= req_len;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end

        FETCH: begin
          rd_data <= load_word;
          rd_addr <= load_addr;
          rd_last <= (remaining == '0);
`ifdef ROM_PARITY_EN
          rd_parity <= ^load_word;
`endif
          state   <= BEAT;
        end

        BEAT: begin
          if (!rd_valid) begin
            // First BEAT cycle: output registers were loaded by FETCH on the
            // previous edge; offer them now, giving the two-edge request latency.
            rd_valid <= 1'b1;
          end else if (rd_ready) begin
            if (rd_last) begin
              // Ready only rises after this edge, so no accept can coincide
              // with the final beat.
              rd_valid  <= 1'b0;
              rd_last   <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              cur_addr  <= next_addr;
              remaining <= remaining - LEN_W'(1);
              rd_data   <= load_word;
              rd_addr   <= load_addr;
              rd_last   <= (remaining == LEN_W'(1));
`ifdef ROM_PARITY_EN
              rd_parity <= ^load_word;
`endif
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_ctrl.sv
// Purpose : directed + randomized checks of rom_burst_ctrl against a formula-based ROM model.
// Latency : checks first rd_valid two edges after the accept edge.
// Backpr. : random and directed rd_ready stalls; presented beat must repeat unchanged.
module tb_rom_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr = '0;
  logic [2:0]  req_len = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic [3:0]  rd_addr;
  logic        rd_last;
  logic        busy;
`ifdef ROM_PARITY_EN
  logic        rd_parity;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] got [$];

  always #5 clk = ~clk;

  rom_burst_ctrl #(.ADDR_W(4), .DATA_W(16), .LEN_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_last   (rd_last),
    .busy      (busy)
`ifdef ROM_PARITY_EN
    ,
    .rd_parity (rd_parity)
`endif
  );

  // Reference ROM straight from the content formula.
  function automatic logic [15:0] word(input logic [3:0] a);
    int unsigned v;
    v = int'(a) * 32'h1111 + 32'd1;
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete burst. stall_mask bit i = 1 drops rd_ready in beat-loop cycle i.
  // hold_req keeps a competing request (addr 9) asserted for the whole burst.
  task automatic run_burst(input logic [3:0] a, input logic [2:0] l,
                           input logic [31:0] stall_mask, input bit hold_req);
    int k;
    int it;
    int waitc;
    logic [3:0]  ea;
    logic [15:0] seen;
    got.delete();
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    check("req_ready_idle", req_ready, 1);
    check("busy_idle", busy, 0);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    rd_ready  = 1'b0;
    tick();                                   // accept edge N
    if (hold_req) begin
      req_addr = 4'd9;
      req_len  = 3'd0;
    end else begin
      req_valid = 1'b0;
    end
    check("req_ready_fetch", req_ready, 0);
    check("busy_fetch", busy, 1);
    check("rd_valid_after_n", rd_valid, 0);
    tick();                                   // edge N+1
    check("rd_valid_after_n1", rd_valid, 0);
    tick();                                   // edge N+2: first beat must be offered
    k = 0;
    it = 0;
    while (k <= int'(l) && it < 64) begin
      ea = a + 4'(k);
      check("rd_valid_beat", rd_valid, 1);
      check("rd_data", rd_data, word(ea));
      check("rd_addr", rd_addr, ea);
      check("rd_last", rd_last, (k == int'(l)) ? 1 : 0);
`ifdef ROM_PARITY_EN
      check("rd_parity", rd_parity, ^word(ea));
`endif
      if (hold_req) check("req_ready_busy", req_ready, 0);
      seen = rd_data;
      rd_ready = (it < 32) ? ~stall_mask[it] : 1'b1;
      if (k == int'(l) && rd_ready) req_valid = 1'b0;
      tick();
      if (rd_ready) begin
        got.push_back(seen);
        k++;
      end
      it++;
    end
    rd_ready  = 1'b0;
    req_valid = 1'b0;
    check("beats_delivered", k, int'(l) + 1);
    check("rd_valid_done", rd_valid, 0);
    check("req_ready_done", req_ready, 1);
    check("busy_done", busy, 0);
  endtask

  initial begin
    logic [15:0] exp23 [4];
    logic [15:0] exp24 [3];
    logic [3:0]  ra;
    logic [2:0]  rl;
    exp23 = '{16'hEEEF, 16'h0000, 16'h0001, 16'h1112};
    exp24 = '{16'h2223, 16'h3334, 16'h4445};

    // Reset state.
    #1;
    tick();
    tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_last", rd_last, 0);
`ifdef ROM_PARITY_EN
    check("rst_rd_parity", rd_parity, 0);
`endif
    rst_n = 1'b1;
    check("rst_req_ready", req_ready, 1);

    // Single read, latency and return to idle.
    run_burst(4'd5, 3'd0, 32'h0, 1'b0);
    check("single_data", got[0], 16'h5556);

    // Wrapped burst.
    run_burst(4'd14, 3'd3, 32'h0, 1'b0);
    check("wrap_count", got.size(), 4);
    for (int i = 0; i < 4; i++) check("wrap_seq", got[i], exp23[i]);

    // Backpressure: three stall cycles after the first beat.
    run_burst(4'd2, 3'd2, 32'b1110, 1'b0);
    check("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++) check("bp_seq", got[i], exp24[i]);

    // Competing request held throughout a long burst, then served.
    run_burst(4'd0, 3'd7, 32'h0, 1'b1);
    run_burst(4'd9, 3'd0, 32'h0, 1'b0);
    check("busy_reject_data", got[0], 16'h999A);

`ifdef ROM_PARITY_EN
    run_burst(4'd0, 3'd0, 32'h0, 1'b0);
    check("parity_addr0_data", got[0], 16'h0001);
`endif

    // Reset asserted during the third beat.
    req_valid = 1'b1;
    req_addr  = 4'd0;
    req_len   = 3'd7;
    tick();
    req_valid = 1'b0;
    rd_ready  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("mid_beat3_addr", rd_addr, 2);
    check("mid_beat3_valid", rd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", rd_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_data", rd_data, 0);
    check("async_rst_last", rd_last, 0);
    rd_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("post_rst_no_resume", rd_valid, 0);
    run_burst(4'd1, 3'd0, 32'h0, 1'b0);
    check("post_rst_data", got[0], 16'h1112);

    // Randomized bursts with random stalls.
    for (int n = 0; n < 12; n++) begin
      ra = 4'($urandom_range(0, 15));
      rl = 3'($urandom_range(0, 7));
      run_burst(ra, rl, $urandom & $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_burst_ctrl.md
ROM_BURST_CTRL -- requirements
Module: rom_burst_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 4, address width; depth is 2^ADDR_W.
- DATA_W, default 16, word width.
- LEN_W, default 3, burst-length field width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- req_valid, in, 1, request offered.
- req_ready, out, 1, request can be accepted.
- req_addr, in, ADDR_W, start address.
- req_len, in, LEN_W, beats minus 1.
- rd_valid, out, 1, read beat present.
- rd_ready, in, 1, consumer accepts beat.
- rd_data, out, DATA_W, word read.
- rd_addr, out, ADDR_W, address of rd_data.
- rd_last, out, 1, final beat of burst.
- busy, out, 1, burst in progress.

Function
REQ-003 ROM contents SHALL be word(a) = (a * 0x1111 + 1) mod 2^DATA_W, fixed at elaboration; no write path.
REQ-004 FSM states SHALL be IDLE, FETCH and BEAT.
REQ-005 IDLE: req_ready=1, rd_valid=0, busy=0; req_valid&&req_ready latches req_addr and req_len and goes to FETCH.
REQ-006 FETCH SHALL last one cycle and register word(cur_addr), cur_addr and (remaining==0) into rd_data, rd_addr and rd_last, then go to BEAT.
REQ-007 Latency: with the accept at clock edge N, rd_valid SHALL be first high after edge N+2.
REQ-008 BEAT: rd_valid=1; on rd_valid&&rd_ready with rd_last=0, load next word (cur_addr+1) on the same edge and stay in BEAT, giving one beat per cycle.
REQ-009 BEAT: on rd_valid&&rd_ready with rd_last=1, go to IDLE; req_ready SHALL rise the following cycle, with no back-to-back accept in the same edge.
REQ-010 While rd_valid=1 and rd_ready=0, rd_data, rd_addr and rd_last SHALL hold stable; no beat is dropped or duplicated.
REQ-011 Addresses SHALL increment modulo 2^ADDR_W: beat after address 2^ADDR_W-1 reads address 0.
REQ-012 A burst SHALL deliver exactly req_len+1 beats, with rd_last high only on the final beat.
REQ-013 req_ready SHALL be 0 in FETCH and BEAT; req_valid there SHALL be ignored, with no latching and no queueing.
REQ-014 busy SHALL be 1 in FETCH and BEAT.

Reset
REQ-015 rst_n low SHALL immediately (asynchronously) force state=IDLE, rd_valid=0, rd_last=0, busy=0, rd_data=0, rd_addr=0, and internal counters to 0.
REQ-016 req_ready SHALL be 1 while in IDLE after reset is released.
REQ-017 Reset mid-burst SHALL abort the burst; remaining beats are discarded and not resumed.
REQ-018 The first clock edge after rst_n deasserts SHALL be able to accept a request.

Configuration
REQ-019 With macro ROM_PARITY_EN defined, output port rd_parity (1 bit) SHALL exist and equal XOR-reduction of rd_data, registered with rd_data and held stable under REQ-010.
REQ-020 rd_parity SHALL reset to 0.
REQ-021 Without ROM_PARITY_EN, rd_parity SHALL be absent and all other behaviour identical.

Verification (defaults ADDR_W=4, DATA_W=16, LEN_W=3)
REQ-022 Single read: addr=5, len=0, rd_ready=1 -> one beat, rd_data=0x5556, rd_addr=5, rd_last=1, rd_valid first high 2 edges after accept; req_ready=1 the cycle after the beat.
REQ-023 Wrapped burst: addr=14, len=3, rd_ready=1 -> rd_data 0xEEEF, 0x0000, 0x0001, 0x1112 on consecutive cycles, rd_addr 14, 15, 0, 1, rd_last only on the 4th beat.
REQ-024 Backpressure: addr=2, len=2, rd_ready low 3 cycles after the first beat -> 0x3334 held stable for those 3 cycles; delivered sequence exactly 0x2223, 0x3334, 0x4445.
REQ-025 Busy rejection: req_valid with addr=9 asserted throughout a burst of addr=0, len=7 -> req_ready=0 for all 8 beats, addr 9 not read; after return to IDLE, addr 9 accepted and rd_data=0x999A.
REQ-026 Reset mid-burst: rst_n low during the 3rd beat of addr=0, len=7 -> rd_valid=0 and busy=0 without a clock edge; after release, addr=1, len=0 returns 0x1112.
REQ-027 With ROM_PARITY_EN: addr=0 -> rd_parity=1 (0x0001); addr=5 -> rd_parity=0 (0x5556).
